// File: rtl/ibex_trace_capture.sv
// ibex_trace_capture
// -----------------------------------------------------------------------------
// On-chip retirement trace buffer. It consumes the RVFI retirement stream and
// captures retired-instruction records into a circular buffer. A trigger
// (PC match under mask, or a trap) freezes the window a programmable number of
// retirements later. The frozen window is then drained oldest-first over a
// valid/ready stream.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   arm_i               pulse: clear the buffer and start capture (highest priority)
//   mode_i              0 = WRAP (overwrite oldest), 1 = ONESHOT (stop when full)
//   trig_pc_en_i        enable the PC-match trigger
//   trig_pc_i           PC compare value
//   trig_pc_mask_i      compare mask (1 = bit takes part in the compare)
//   trig_trap_en_i      enable the trap trigger
//   post_count_i        retirements to capture after the trigger record
//   rvfi_*              retirement stream from the core
//   rd_valid_o          drain record available (DONE and not empty)
//   rd_ready_i          drain consumer ready
//   rd_data_o           {trap, intr, rd_addr, pc, insn, rd_wdata}, MSB first
//   state_o             0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   fill_o              number of valid entries held
//   triggered_o         sticky: trigger seen since arm
//   overflow_o          sticky: at least one record overwritten since arm
// -----------------------------------------------------------------------------
module ibex_trace_capture #(
  parameter int Depth       = 64,
  parameter int PostTrigMax = 255,
  localparam int RecWidth   = 103,
  localparam int PW         = $clog2(PostTrigMax + 1),
  localparam int AW         = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                arm_i,
  input  logic                mode_i,
  input  logic                trig_pc_en_i,
  input  logic [31:0]         trig_pc_i,
  input  logic [31:0]         trig_pc_mask_i,
  input  logic                trig_trap_en_i,
  input  logic [PW-1:0]       post_count_i,
  input  logic                rvfi_valid,
  input  logic [31:0]         rvfi_pc_rdata,
  input  logic [31:0]         rvfi_insn,
  input  logic                rvfi_trap,
  input  logic                rvfi_intr,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [RecWidth-1:0] rd_data_o,
  output logic [1:0]          state_o,
  output logic [AW:0]         fill_o,
  output logic                triggered_o,
  output logic                overflow_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] POST  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [AW:0]   FULL    = (AW + 1)'(Depth);
  localparam logic [AW:0]   FILL1   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR1    = AW'(1);
  localparam logic [PW-1:0] POST1   = PW'(1);

  logic [1:0]          state;
  logic                mode_q;      // 1 = ONESHOT, latched at arm
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         fill;
  logic [PW-1:0]       post_cnt;
  logic                triggered;
  logic                overflow;

  logic [RecWidth-1:0] mem [Depth];

  logic                capture;
  logic                hit;
  logic                full;
  logic                oneshot_last;
  logic                pop;
  logic [RecWidth-1:0] rec;

  // NOTE: every signal driven here gets a value on every path (defaults first),
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    full         = 1'b0;
    capture      = 1'b0;
    hit          = 1'b0;
    oneshot_last = 1'b0;
    pop          = 1'b0;

    full = (fill == FULL);
    // A ONESHOT buffer that is already full never accepts another record;
    // arm_i wins over any retirement in the same cycle.
    capture = ((state == ARMED) || (state == POST)) && rvfi_valid && !arm_i &&
              !(mode_q && full);
    hit = (state == ARMED) && rvfi_valid &&
          ((trig_pc_en_i && (((rvfi_pc_rdata ^ trig_pc_i) & trig_pc_mask_i) == 32'h0)) ||
           (trig_trap_en_i && rvfi_trap));
    // This write is the one that fills a ONESHOT buffer: it is stored, then we stop.
    oneshot_last = mode_q && (fill == (FULL - FILL1));
    pop = (state == DONE) && (fill != '0) && rd_ready_i && !arm_i;
  end

  assign rec = {rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else if (arm_i) begin
      state     <= ARMED;
      mode_q    <= mode_i;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ARMED, POST: begin
          if (capture) begin
            wr_ptr <= wr_ptr + PTR1;
            if (full) begin
              // WRAP only: the new record replaces the oldest one.
              rd_ptr   <= rd_ptr + PTR1;
              overflow <= 1'b1;
            end else begin
              fill <= fill + FILL1;
            end

            if (hit) begin
              triggered <= 1'b1;
              post_cnt  <= post_count_i;
              // Filling a ONESHOT buffer takes precedence over entering POST.
              if (oneshot_last || (post_count_i == '0)) state <= DONE;
              else                                       state <= POST;
            end else if (state == POST) begin
              post_cnt <= post_cnt - POST1;
              if ((post_cnt == POST1) || oneshot_last) state <= DONE;
            end else if (oneshot_last) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (pop) begin
            rd_ptr <= rd_ptr + PTR1;
            fill   <= fill - FILL1;
            if (fill == FILL1) state <= IDLE;
          end else if (fill == '0) begin
            state <= IDLE;
          end
        end

        default: ;
      endcase
    end
  end

  // NOTE: the record store has no reset; its contents are only ever read
  // behind fill, so clearing it would buy nothing.
  always_ff @(posedge clk_i) begin
    if (capture) mem[wr_ptr] <= rec;
  end

  assign rd_valid_o  = (state == DONE) && (fill != '0);
  assign rd_data_o   = mem[rd_ptr];
  assign state_o     = state;
  assign fill_o      = fill;
  assign triggered_o = triggered;
  assign overflow_o  = overflow;

endmodule
